// File: rtl/wb_stage.sv
`default_nettype none
// ============================================================================
//  Module   : wb_stage
//  Purpose  : MEM/WB pipeline register and writeback stage of the RV32
//             five-stage pipeline. Captures the MEM-stage result, extends
//             load data, selects the writeback value and drives the
//             register-file write port plus the WB forwarding path.
//  Options  : WB_RETIRE_CNT_EN - when defined, a 64-bit retired-instruction
//             counter is built; otherwise retire_cnt is tied to zero.
//  Revision : 1.0 - initial release
// ============================================================================
module wb_stage (
    input  logic        cpu_clk,
    input  logic        cpu_rst,
    input  logic        mem_valid,
    input  logic [31:0] mem_pc,
    input  logic [4:0]  mem_rd,
    input  logic        mem_rf_we,
    input  logic [1:0]  mem_wb_sel,
    input  logic [31:0] mem_alu_res,
    input  logic [31:0] mem_imm,
    input  logic [31:0] mem_ld_data,
    input  logic [2:0]  mem_ld_type,
    input  logic        wb_stall,
    input  logic        wb_flush,
    output logic        rf_we,
    output logic [4:0]  rf_wR,
    output logic [31:0] rf_wD,
    output logic        fwd_valid,
    output logic [4:0]  fwd_rd,
    output logic [31:0] fwd_data,
    output logic        wb_valid,
    output logic [31:0] wb_pc,
    output logic [63:0] retire_cnt
);

    // Writeback source encodings
    localparam logic [1:0] c_SEL_ALU  = 2'b00;
    localparam logic [1:0] c_SEL_LOAD = 2'b01;
    localparam logic [1:0] c_SEL_PC4  = 2'b10;
    localparam logic [1:0] c_SEL_IMM  = 2'b11;

    // Load funct3 encodings
    localparam logic [2:0] c_LD_LB  = 3'b000;
    localparam logic [2:0] c_LD_LH  = 3'b001;
    localparam logic [2:0] c_LD_LW  = 3'b010;
    localparam logic [2:0] c_LD_LBU = 3'b100;
    localparam logic [2:0] c_LD_LHU = 3'b101;

    // ------------------------------------------------------------------
    // WB pipeline register fields
    // ------------------------------------------------------------------
    logic        valid_q,   valid_d;
    logic [31:0] pc_q,      pc_d;
    logic [4:0]  rd_q,      rd_d;
    logic        rf_we_q,   rf_we_d;
    logic [1:0]  wb_sel_q,  wb_sel_d;
    logic [31:0] alu_res_q, alu_res_d;
    logic [31:0] imm_q,     imm_d;
    logic [31:0] ld_data_q, ld_data_d;
    logic [2:0]  ld_type_q, ld_type_d;

    // Combinational datapath
    logic [7:0]  w_ld_byte;
    logic [15:0] w_ld_half;
    logic [31:0] w_ld_ext;
    logic [31:0] w_pc_plus4;
    logic [31:0] w_wb_data;
    logic        w_rf_we;

    // Next-state selection: flush kills, stall holds, otherwise capture MEM
    always_comb begin
        valid_d   = valid_q;
        pc_d      = pc_q;
        rd_d      = rd_q;
        rf_we_d   = rf_we_q;
        wb_sel_d  = wb_sel_q;
        alu_res_d = alu_res_q;
        imm_d     = imm_q;
        ld_data_d = ld_data_q;
        ld_type_d = ld_type_q;
        if (wb_flush) begin
            // Only valid matters after a flush; zero the rest for clean traces
            valid_d   = 1'b0;
            pc_d      = 32'd0;
            rd_d      = 5'd0;
            rf_we_d   = 1'b0;
            wb_sel_d  = 2'd0;
            alu_res_d = 32'd0;
            imm_d     = 32'd0;
            ld_data_d = 32'd0;
            ld_type_d = 3'd0;
        end else if (!wb_stall) begin
            valid_d   = mem_valid;
            pc_d      = mem_pc;
            rd_d      = mem_rd;
            rf_we_d   = mem_rf_we;
            wb_sel_d  = mem_wb_sel;
            alu_res_d = mem_alu_res;
            imm_d     = mem_imm;
            ld_data_d = mem_ld_data;
            ld_type_d = mem_ld_type;
        end
    end

    // WB register update with synchronous reset taking precedence
    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            valid_q   <= 1'b0;
            pc_q      <= 32'd0;
            rd_q      <= 5'd0;
            rf_we_q   <= 1'b0;
            wb_sel_q  <= 2'd0;
            alu_res_q <= 32'd0;
            imm_q     <= 32'd0;
            ld_data_q <= 32'd0;
            ld_type_q <= 3'd0;
        end else begin
            valid_q   <= valid_d;
            pc_q      <= pc_d;
            rd_q      <= rd_d;
            rf_we_q   <= rf_we_d;
            wb_sel_q  <= wb_sel_d;
            alu_res_q <= alu_res_d;
            imm_q     <= imm_d;
            ld_data_q <= ld_data_d;
            ld_type_q <= ld_type_d;
        end
    end

    // Byte and halfword lane selection from the stored raw word
    always_comb begin
        w_ld_byte = ld_data_q[7:0];
        unique case (alu_res_q[1:0])
            2'd0:    w_ld_byte = ld_data_q[7:0];
            2'd1:    w_ld_byte = ld_data_q[15:8];
            2'd2:    w_ld_byte = ld_data_q[23:16];
            default: w_ld_byte = ld_data_q[31:24];
        endcase
        // Halfword offset bit 0 is ignored: misaligned halves are not split
        w_ld_half = alu_res_q[1] ? ld_data_q[31:16] : ld_data_q[15:0];
    end

    // Load sign/zero extension; unsupported funct3 values pass the raw word
    always_comb begin
        w_ld_ext = ld_data_q;
        case (ld_type_q)
            c_LD_LB:  w_ld_ext = {{24{w_ld_byte[7]}}, w_ld_byte};
            c_LD_LBU: w_ld_ext = {24'd0, w_ld_byte};
            c_LD_LH:  w_ld_ext = {{16{w_ld_half[15]}}, w_ld_half};
            c_LD_LHU: w_ld_ext = {16'd0, w_ld_half};
            c_LD_LW:  w_ld_ext = ld_data_q;
            default:  w_ld_ext = ld_data_q;
        endcase
    end

    // Link address wraps naturally at 32 bits
    assign w_pc_plus4 = pc_q + 32'd4;

    // Writeback value mux
    always_comb begin
        w_wb_data = alu_res_q;
        unique case (wb_sel_q)
            c_SEL_ALU:  w_wb_data = alu_res_q;
            c_SEL_LOAD: w_wb_data = w_ld_ext;
            c_SEL_PC4:  w_wb_data = w_pc_plus4;
            c_SEL_IMM:  w_wb_data = imm_q;
            default:    w_wb_data = alu_res_q;
        endcase
    end

    // x0 is hardwired: never write it and never forward from it.
    // A stalled live instruction keeps rf_we high; rewriting is idempotent.
    assign w_rf_we = valid_q & rf_we_q & (rd_q != 5'd0);

    assign rf_we     = w_rf_we;
    assign rf_wR     = rd_q;
    assign rf_wD     = w_wb_data;
    assign fwd_valid = w_rf_we;
    assign fwd_rd    = rd_q;
    assign fwd_data  = w_wb_data;
    assign wb_valid  = valid_q;
    assign wb_pc     = pc_q;

`ifdef WB_RETIRE_CNT_EN
    logic [63:0] retire_cnt_q;

    // An instruction retires on the edge it leaves WB (live and not stalled)
    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            retire_cnt_q <= 64'd0;
        end else if (valid_q && !wb_stall) begin
            retire_cnt_q <= retire_cnt_q + 64'd1;
        end
    end

    assign retire_cnt = retire_cnt_q;
`else
    assign retire_cnt = 64'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_wb_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_wb_stage
//  Purpose  : Directed self-checking bench for wb_stage.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_wb_stage;

    logic        clk;
    logic        rst;
    logic        mem_valid;
    logic [31:0] mem_pc;
    logic [4:0]  mem_rd;
    logic        mem_rf_we;
    logic [1:0]  mem_wb_sel;
    logic [31:0] mem_alu_res;
    logic [31:0] mem_imm;
    logic [31:0] mem_ld_data;
    logic [2:0]  mem_ld_type;
    logic        wb_stall;
    logic        wb_flush;
    logic        rf_we;
    logic [4:0]  rf_wR;
    logic [31:0] rf_wD;
    logic        fwd_valid;
    logic [4:0]  fwd_rd;
    logic [31:0] fwd_data;
    logic        wb_valid;
    logic [31:0] wb_pc;
    logic [63:0] retire_cnt;

    int n_checks;
    int n_fail;

`ifdef WB_RETIRE_CNT_EN
    localparam logic [63:0] c_CNT_ONE = 64'd1;
`else
    localparam logic [63:0] c_CNT_ONE = 64'd0;
`endif

    wb_stage u_dut (
        .cpu_clk     (clk),
        .cpu_rst     (rst),
        .mem_valid   (mem_valid),
        .mem_pc      (mem_pc),
        .mem_rd      (mem_rd),
        .mem_rf_we   (mem_rf_we),
        .mem_wb_sel  (mem_wb_sel),
        .mem_alu_res (mem_alu_res),
        .mem_imm     (mem_imm),
        .mem_ld_data (mem_ld_data),
        .mem_ld_type (mem_ld_type),
        .wb_stall    (wb_stall),
        .wb_flush    (wb_flush),
        .rf_we       (rf_we),
        .rf_wR       (rf_wR),
        .rf_wD       (rf_wD),
        .fwd_valid   (fwd_valid),
        .fwd_rd      (fwd_rd),
        .fwd_data    (fwd_data),
        .wb_valid    (wb_valid),
        .wb_pc       (wb_pc),
        .retire_cnt  (retire_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge and settle away from it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_mem(input logic v, input logic [31:0] pc, input logic [4:0] rd,
                           input logic we, input logic [1:0] sel, input logic [31:0] alu,
                           input logic [31:0] imm, input logic [31:0] ld, input logic [2:0] lt);
        mem_valid   = v;
        mem_pc      = pc;
        mem_rd      = rd;
        mem_rf_we   = we;
        mem_wb_sel  = sel;
        mem_alu_res = alu;
        mem_imm     = imm;
        mem_ld_data = ld;
        mem_ld_type = lt;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        set_mem(1'b0, 32'd0, 5'd0, 1'b0, 2'd0, 32'd0, 32'd0, 32'd0, 3'd0);
        wb_stall = 1'b0;
        wb_flush = 1'b0;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if ({wb_valid, wb_pc, rf_we, rf_wR, rf_wD, fwd_valid, fwd_rd, fwd_data, retire_cnt} !== '0) begin
                n_fail++;
                $display("FAIL reset_idle cyc%0d: got v=%b pc=%h we=%b wR=%0d wD=%h fv=%b frd=%0d fd=%h cnt=%0d required all zero",
                         i, wb_valid, wb_pc, rf_we, rf_wR, rf_wD, fwd_valid, fwd_rd, fwd_data, retire_cnt);
            end
            tick();
        end
        // Dead instruction with a nonzero rd must not write
        set_mem(1'b0, 32'h100, 5'd5, 1'b1, 2'd0, 32'h55, 32'd0, 32'd0, 3'd0);
        tick();
        n_checks++;
        if ({wb_valid, rf_we, fwd_valid} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_dead_rd5: got v=%b we=%b fv=%b required 000", wb_valid, rf_we, fwd_valid);
        end
    endtask

    task automatic test_alu();
        set_mem(1'b1, 32'h0000_2000, 5'd3, 1'b1, 2'b00, 32'h1234_5678, 32'd0, 32'd0, 3'd0);
        tick();
        n_checks++;
        if ({rf_we, rf_wR, rf_wD, fwd_valid, fwd_rd, fwd_data, wb_valid, wb_pc} !==
            {1'b1, 5'd3, 32'h1234_5678, 1'b1, 5'd3, 32'h1234_5678, 1'b1, 32'h0000_2000}) begin
            n_fail++;
            $display("FAIL alu_rd3: got we=%b wR=%0d wD=%h fv=%b frd=%0d fd=%h v=%b pc=%h required 1 3 12345678 1 3 12345678 1 00002000",
                     rf_we, rf_wR, rf_wD, fwd_valid, fwd_rd, fwd_data, wb_valid, wb_pc);
        end
        set_mem(1'b1, 32'h0000_2004, 5'd0, 1'b1, 2'b00, 32'h1234_5678, 32'd0, 32'd0, 3'd0);
        tick();
        n_checks++;
        if ({rf_we, fwd_valid, wb_valid, rf_wD} !== {1'b0, 1'b0, 1'b1, 32'h1234_5678}) begin
            n_fail++;
            $display("FAIL alu_rd0: got we=%b fv=%b v=%b wD=%h required 0 0 1 12345678", rf_we, fwd_valid, wb_valid, rf_wD);
        end
        // Live instruction without rf_we
        set_mem(1'b1, 32'h0000_2008, 5'd4, 1'b0, 2'b00, 32'hCAFE_0000, 32'd0, 32'd0, 3'd0);
        tick();
        n_checks++;
        if ({rf_we, rf_wR, rf_wD} !== {1'b0, 5'd4, 32'hCAFE_0000}) begin
            n_fail++;
            $display("FAIL alu_nowe: got we=%b wR=%0d wD=%h required 0 4 cafe0000", rf_we, rf_wR, rf_wD);
        end
    endtask

    // Back-to-back loads, one per cycle, each checked the cycle after entry
    task automatic test_loads();
        logic [31:0] exp_tbl [0:7];
        logic [2:0]  lt_tbl  [0:7];
        logic [31:0] off_tbl [0:7];
        lt_tbl[0] = 3'b000; off_tbl[0] = 32'h1003; exp_tbl[0] = 32'hFFFF_FF80; // LB  +3
        lt_tbl[1] = 3'b100; off_tbl[1] = 32'h1001; exp_tbl[1] = 32'h0000_007F; // LBU +1
        lt_tbl[2] = 3'b001; off_tbl[2] = 32'h1002; exp_tbl[2] = 32'hFFFF_80FF; // LH  +2
        lt_tbl[3] = 3'b101; off_tbl[3] = 32'h1000; exp_tbl[3] = 32'h0000_7F01; // LHU +0
        lt_tbl[4] = 3'b010; off_tbl[4] = 32'h1003; exp_tbl[4] = 32'h80FF_7F01; // LW
        lt_tbl[5] = 3'b000; off_tbl[5] = 32'h1000; exp_tbl[5] = 32'h0000_0001; // LB  +0
        lt_tbl[6] = 3'b101; off_tbl[6] = 32'h1003; exp_tbl[6] = 32'h0000_80FF; // LHU +3 (bit0 ignored)
        lt_tbl[7] = 3'b111; off_tbl[7] = 32'h1001; exp_tbl[7] = 32'h80FF_7F01; // raw
        for (int i = 0; i < 8; i++) begin
            set_mem(1'b1, 32'h3000 + 32'(i * 4), 5'(10 + i), 1'b1, 2'b01, off_tbl[i], 32'd0,
                    32'h80FF_7F01, lt_tbl[i]);
            tick();
            n_checks++;
            if ({rf_we, rf_wR, rf_wD, fwd_data} !== {1'b1, 5'(10 + i), exp_tbl[i], exp_tbl[i]}) begin
                n_fail++;
                $display("FAIL load_%0d: got we=%b wR=%0d wD=%h fd=%h required 1 %0d %h", i,
                         rf_we, rf_wR, rf_wD, fwd_data, 10 + i, exp_tbl[i]);
            end
        end
    endtask

    task automatic test_jal_lui();
        set_mem(1'b1, 32'hFFFF_FFFC, 5'd1, 1'b1, 2'b10, 32'h1111_1111, 32'h2222_2222, 32'd0, 3'd0);
        tick();
        n_checks++;
        if (rf_wD !== 32'h0000_0000) begin
            n_fail++;
            $display("FAIL jal_wrap: got wD=%h required 00000000", rf_wD);
        end
        set_mem(1'b1, 32'h0000_1000, 5'd1, 1'b1, 2'b10, 32'h1111_1111, 32'h2222_2222, 32'd0, 3'd0);
        tick();
        n_checks++;
        if (rf_wD !== 32'h0000_1004) begin
            n_fail++;
            $display("FAIL jal_link: got wD=%h required 00001004", rf_wD);
        end
        set_mem(1'b1, 32'h0000_1004, 5'd2, 1'b1, 2'b11, 32'h1111_1111, 32'hABCD_E000, 32'd0, 3'd0);
        tick();
        n_checks++;
        if ({rf_we, rf_wR, rf_wD} !== {1'b1, 5'd2, 32'hABCD_E000}) begin
            n_fail++;
            $display("FAIL lui: got we=%b wR=%0d wD=%h required 1 2 abcde000", rf_we, rf_wR, rf_wD);
        end
    endtask

    task automatic test_stall();
        set_mem(1'b0, 32'd0, 5'd0, 1'b0, 2'd0, 32'd0, 32'd0, 32'd0, 3'd0);
        do_reset();
        set_mem(1'b1, 32'h0000_4000, 5'd7, 1'b1, 2'b00, 32'hDEAD_BEEF, 32'd0, 32'd0, 3'd0);
        tick();
        // MEM now offers a different instruction which must not be taken
        set_mem(1'b1, 32'h0000_4004, 5'd9, 1'b1, 2'b00, 32'h0000_1111, 32'd0, 32'd0, 3'd0);
        wb_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if ({rf_we, rf_wR, rf_wD, wb_valid, wb_pc, retire_cnt} !==
                {1'b1, 5'd7, 32'hDEAD_BEEF, 1'b1, 32'h0000_4000, 64'd0}) begin
                n_fail++;
                $display("FAIL stall_hold%0d: got we=%b wR=%0d wD=%h v=%b pc=%h cnt=%0d required 1 7 deadbeef 1 00004000 0",
                         i, rf_we, rf_wR, rf_wD, wb_valid, wb_pc, retire_cnt);
            end
        end
        wb_stall = 1'b0;
        set_mem(1'b0, 32'd0, 5'd0, 1'b0, 2'd0, 32'd0, 32'd0, 32'd0, 3'd0);
        tick();
        n_checks++;
        if ({wb_valid, retire_cnt} !== {1'b0, c_CNT_ONE}) begin
            n_fail++;
            $display("FAIL stall_release: got v=%b cnt=%0d required 0 %0d", wb_valid, retire_cnt, c_CNT_ONE);
        end
    endtask

    task automatic test_stall_flush();
        set_mem(1'b1, 32'h0000_5000, 5'd6, 1'b1, 2'b00, 32'h0BAD_F00D, 32'd0, 32'd0, 3'd0);
        tick();
        wb_stall = 1'b1;
        wb_flush = 1'b1;
        tick();
        wb_stall = 1'b0;
        wb_flush = 1'b0;
        n_checks++;
        if ({wb_valid, rf_we, fwd_valid, retire_cnt} !== {1'b0, 1'b0, 1'b0, c_CNT_ONE}) begin
            n_fail++;
            $display("FAIL stall_flush: got v=%b we=%b fv=%b cnt=%0d required 0 0 0 %0d",
                     wb_valid, rf_we, fwd_valid, retire_cnt, c_CNT_ONE);
        end
        // Reset during stall clears state including the counter
        set_mem(1'b1, 32'h0000_6000, 5'd8, 1'b1, 2'b00, 32'h7777_7777, 32'd0, 32'd0, 3'd0);
        tick();
        wb_stall = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        wb_stall = 1'b0;
        set_mem(1'b0, 32'd0, 5'd0, 1'b0, 2'd0, 32'd0, 32'd0, 32'd0, 3'd0);
        n_checks++;
        if ({wb_valid, wb_pc, rf_we, rf_wR, rf_wD, retire_cnt} !== '0) begin
            n_fail++;
            $display("FAIL reset_in_stall: got v=%b pc=%h we=%b wR=%0d wD=%h cnt=%0d required all zero",
                     wb_valid, wb_pc, rf_we, rf_wR, rf_wD, retire_cnt);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        wb_stall = 1'b0;
        wb_flush = 1'b0;
        set_mem(1'b0, 32'd0, 5'd0, 1'b0, 2'd0, 32'd0, 32'd0, 32'd0, 3'd0);
        test_reset();
        test_alu();
        test_loads();
        test_jal_lui();
        test_stall();
        test_stall_flush();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
